counting_up: RTL

// - Elapsed-time stopwatch; mirrors the countdown timer in the LED/7-seg subsystem.
// - Counts whole seconds up from 0 after start and freezes on stop_in.
// - Reports the count as binary and on the 4-digit 7-seg display.
// - Measures operator/calculation time; the value is read by the top-level controller.

---
 rtl/timer_pkg.sv | 57 +++++
 rtl/seg7_scan.sv | 41 ++++
 rtl/counting_up.sv | 106 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the stopwatch / countdown timer blocks.
// Holds the FSM state encoding, the BCD digit types and the 7-segment decoder.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        SAT  = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DIGITS    = 4;

    typedef logic [3:0]           bcd_t;
    typedef bcd_t [DIGITS-1:0]    bcd4_t;

    // Active-low {dp,g,f,e,d,c,b,a}; dp stays dark, non-decimal codes blank.
    function automatic logic [7:0] seg7_decode(input bcd_t d);
        logic [7:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 8'hC0;
            4'd1: s = 8'hF9;
            4'd2: s = 8'hA4;
            4'd3: s = 8'hB0;
            4'd4: s = 8'h99;
            4'd5: s = 8'h92;
            4'd6: s = 8'h82;
            4'd7: s = 8'hF8;
            4'd8: s = 8'h80;
            4'd9: s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic bcd4_t bcd_inc(input bcd4_t v);
        bcd4_t r;
        logic  carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[i] == 4'd9) begin
                    r[i]  = 4'd0;
                    carry = 1'b1;
                end else begin
                    r[i]  = v[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit 7-segment driver; one digit slot every SCAN_DIV clocks.
// Outputs are registered so an and seg always change together.
module seg7_scan
    import timer_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  bcd4_t      digits,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic          scan_wrap;

    assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            seg      <= SEG_BLANK;
            an       <= 4'hF;
        end else begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            an  <= ~(4'b0001 << idx);
            seg <= seg7_decode(digits[idx]);
        end
    end

endmodule

// File: rtl/counting_up.sv
// Elapsed-seconds stopwatch: edge-detected start/stop, saturating binary+BCD
// counters and a scanned 4-digit display of the BCD value.
module counting_up
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop_in,
    input  logic        clear,
    output logic [15:0] time_out,
    output logic        running,
    output logic        done,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t        state;
    logic          start_q;
    logic          stop_q;
    logic          start_edge;
    logic          stop_edge;
    logic [TW-1:0] tick_cnt;
    logic          tick_wrap;
    logic [15:0]   count;
    logic [15:0]   count_nxt;
    bcd4_t         bcd;

    assign start_edge = start & ~start_q;
    assign stop_edge  = stop_in & ~stop_q;
    assign tick_wrap  = (tick_cnt == TW'(TICK_DIV - 1));
    assign count_nxt  = count + 16'd1;
    assign time_out   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            tick_cnt <= '0;
            count    <= 16'd0;
            bcd      <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop_in;
            done    <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                tick_cnt <= '0;
                count    <= 16'd0;
                bcd      <= '0;
                running  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, HOLD, SAT: begin
                        if (start_edge) begin
                            state    <= RUN;
                            tick_cnt <= '0;
                            count    <= 16'd0;
                            bcd      <= '0;
                            running  <= 1'b1;
                        end
                    end
                    RUN: begin
                        // A stop in the same cycle as a tick drops that tick.
                        if (stop_edge) begin
                            state   <= HOLD;
                            done    <= 1'b1;
                            running <= 1'b0;
                        end else if (tick_wrap) begin
                            tick_cnt <= '0;
                            count    <= count_nxt;
                            bcd      <= bcd_inc(bcd);
                            if (count_nxt == 16'(MAX_COUNT)) begin
                                state   <= SAT;
                                done    <= 1'b1;
                                running <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                endcase
            end
        end
    end

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .digits (bcd),
        .seg    (seg),
        .an     (an)
    );

endmodule
